// File: rtl/fp_pkg.sv
// Shared types and helpers for the unsigned floating-point add sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fp_pkg;

    localparam int E_DEF = 8;
    localparam int M_DEF = 8;

    typedef enum logic [2:0] {
        IDLE,
        ALIGN,
        ADD,
        NORM,
        DONE
    } state_t;

    // Exponent differences beyond M+1 shift the small significand fully out,
    // so the alignment count never needs to exceed M+1.
    function automatic logic [31:0] diff_cap(input logic [31:0] diff, input logic [31:0] mant_w);
        logic [31:0] lim;
        lim = mant_w + 32'd1;
        return (diff > lim) ? lim : diff;
    endfunction

endpackage

// File: rtl/alineador_mantisa.sv
// Right-shift register with a down-counter: shifts the smaller significand one bit per enabled cycle.
// Latency: one shift per enabled cycle until the loaded count reaches zero.
// Backpressure: none; holds its contents whenever not enabled or done.
module alineador_mantisa #(
    parameter int W  = 9,
    parameter int CW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_load,
    input  logic          i_en,
    input  logic [W-1:0]  i_sig,
    input  logic [CW-1:0] i_cnt,
    output logic [W-1:0]  o_sig,
    output logic          o_done
);

    logic [W-1:0]  r_sig;
    logic [CW-1:0] r_cnt;

    // Load on accept, otherwise shift right (zero fill) while count remains.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sig <= '0;
            r_cnt <= '0;
        end else if (i_load) begin
            r_sig <= i_sig;
            r_cnt <= i_cnt;
        end else if (i_en && (r_cnt != '0)) begin
            r_sig <= r_sig >> 1;
            r_cnt <= r_cnt - CW'(1);
        end
    end

    assign o_sig  = r_sig;
    assign o_done = (r_cnt == '0);

endmodule

// File: rtl/controlador_suma_fp.sv
// Sequencer for unsigned FP addition: order by exponent, align, add, one-step carry normalize.
// Latency: out_valid rises cap(diff)+3 cycles after the accepting edge.
// Backpressure: result held in DONE until out_ready; in_ready only in IDLE (one bubble between ops).
module controlador_suma_fp
    import fp_pkg::*;
#(
    parameter int E = E_DEF,
    parameter int M = M_DEF
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [E-1:0] exp_a,
    input  logic [M-1:0] mant_a,
    input  logic [E-1:0] exp_b,
    input  logic [M-1:0] mant_b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [E-1:0] exp_res,
    output logic [M-1:0] mant_res,
    output logic         ovf
);

    localparam int W  = M + 1;
    localparam int CW = $clog2(M + 2);

    state_t        r_state, w_next;
    logic          w_accept, w_align_en, w_align_done;

    logic [W-1:0]  w_sig_a, w_sig_b, w_sig_l, w_sig_s, w_sig_s_al;
    logic [E-1:0]  w_exp_l, w_exp_s, w_diff;
    logic [CW-1:0] w_cnt_init;
    logic          w_swap;

    logic [E-1:0]  r_exp_l;
    logic [W-1:0]  r_sig_l;
    logic          r_cout;
    logic [W-1:0]  r_sum;
    logic [E:0]    w_exp_inc;
    logic [M-1:0]  w_mant_norm;

    logic [E-1:0]  r_exp_res;
    logic [M-1:0]  r_mant_res;
    logic          r_ovf;

    // A zero exponent with zero mantissa encodes 0; everything else carries the hidden 1.
    assign w_sig_a = ((exp_a == '0) && (mant_a == '0)) ? '0 : {1'b1, mant_a};
    assign w_sig_b = ((exp_b == '0) && (mant_b == '0)) ? '0 : {1'b1, mant_b};

    // Larger exponent goes to slot L; ties leave A in L.
    assign w_swap     = (exp_b > exp_a);
    assign w_exp_l    = w_swap ? exp_b   : exp_a;
    assign w_exp_s    = w_swap ? exp_a   : exp_b;
    assign w_sig_l    = w_swap ? w_sig_b : w_sig_a;
    assign w_sig_s    = w_swap ? w_sig_a : w_sig_b;
    assign w_diff     = w_exp_l - w_exp_s;
    assign w_cnt_init = CW'(diff_cap(32'(w_diff), 32'(M)));

    alineador_mantisa #(.W(W), .CW(CW)) u_alineador (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_load (w_accept),
        .i_en   (w_align_en),
        .i_sig  (w_sig_s),
        .i_cnt  (w_cnt_init),
        .o_sig  (w_sig_s_al),
        .o_done (w_align_done)
    );

    // State register; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    // Next-state and control strobes.
    always_comb begin
        w_next     = r_state;
        w_accept   = 1'b0;
        w_align_en = 1'b0;
        case (r_state)
            IDLE: begin
                if (in_valid) begin
                    w_accept = 1'b1;
                    w_next   = ALIGN;
                end
            end
            ALIGN: begin
                if (w_align_done) w_next = ADD;
                else              w_align_en = 1'b1;
            end
            ADD:     w_next = NORM;
            NORM:    w_next = DONE;
            DONE: begin
                if (out_ready) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    // Single-step normalization: a carry shifts right once and bumps the exponent.
    assign w_exp_inc   = {1'b0, r_exp_l} + {{E{1'b0}}, r_cout};
    assign w_mant_norm = r_cout ? r_sum[M:1] : r_sum[M-1:0];

    // Operand capture, significand sum and registered result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_exp_l    <= '0;
            r_sig_l    <= '0;
            r_cout     <= 1'b0;
            r_sum      <= '0;
            r_exp_res  <= '0;
            r_mant_res <= '0;
            r_ovf      <= 1'b0;
        end else begin
            if (w_accept) begin
                r_exp_l <= w_exp_l;
                r_sig_l <= w_sig_l;
                r_ovf   <= 1'b0;
            end
            if (r_state == ADD) begin
                {r_cout, r_sum} <= {1'b0, r_sig_l} + {1'b0, w_sig_s_al};
            end
            if (r_state == NORM) begin
                if (w_exp_inc[E]) begin
                    r_ovf      <= 1'b1;
                    r_exp_res  <= '1;
                    r_mant_res <= '0;
                end else begin
                    r_ovf      <= 1'b0;
                    r_exp_res  <= w_exp_inc[E-1:0];
                    r_mant_res <= w_mant_norm;
                end
            end
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign exp_res   = r_exp_res;
    assign mant_res  = r_mant_res;
    assign ovf       = r_ovf;

endmodule

// File: tb/tb_controlador_suma_fp.sv
// Self-checking bench for controlador_suma_fp: directed table, random ops vs. reference model, corner sequences.
module tb_controlador_suma_fp;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] exp_a, mant_a, exp_b, mant_b;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] exp_res, mant_res;
    logic       ovf;

    int n_chk  = 0;
    int n_fail = 0;

    controlador_suma_fp #(.E(8), .M(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .exp_a     (exp_a),
        .mant_a    (mant_a),
        .exp_b     (exp_b),
        .mant_b    (mant_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .exp_res   (exp_res),
        .mant_res  (mant_res),
        .ovf       (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] ea, ma, eb, mb;
        logic [7:0] xe, xm;
        logic       xo;
        int         xl;
    } vec_t;

    vec_t vt[8];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, req);
        end
    endtask

    // Reference: plain integer arithmetic on the value-level rules, no cycle modelling.
    task automatic model(input int ea, input int ma, input int eb, input int mb,
                         output int xe, output int xm, output int xo, output int xl);
        int sa, sb, sl, ss, el, es, d, s;
        sa = (ea == 0 && ma == 0) ? 0 : 256 + ma;
        sb = (eb == 0 && mb == 0) ? 0 : 256 + mb;
        if (eb > ea) begin el = eb; sl = sb; es = ea; ss = sa; end
        else         begin el = ea; sl = sa; es = eb; ss = sb; end
        d = el - es;
        if (d > 9) d = 9;
        ss = ss >> d;
        s  = sl + ss;
        if (s >= 512) begin xe = el + 1; xm = (s / 2) % 256; end
        else          begin xe = el;     xm = s % 256;       end
        xo = 0;
        if (xe > 255) begin xo = 1; xe = 255; xm = 0; end
        xl = d + 3;
    endtask

    // Issue one operation (entered #1 after a rising edge), wait for the result, then retire it.
    task automatic run_op(input logic [7:0] ea, input logic [7:0] ma,
                          input logic [7:0] eb, input logic [7:0] mb,
                          output logic [7:0] ge, output logic [7:0] gm,
                          output logic go, output int lat);
        exp_a = ea; mant_a = ma; exp_b = eb; mant_b = mb;
        in_valid = 1'b1;
        chk("in_ready_idle", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        exp_a  = 8'($urandom); mant_a = 8'($urandom);
        exp_b  = 8'($urandom); mant_b = 8'($urandom);
        chk("ovf_clr_on_accept", 32'(ovf), 32'd0);
        lat = 0;
        while (out_valid !== 1'b1 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        ge = exp_res; gm = mant_res; go = ovf;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("out_valid_drop", 32'(out_valid), 32'd0);
        chk("in_ready_back", 32'(in_ready), 32'd1);
    endtask

    initial begin
        logic [7:0] ge, gm, ea, ma, eb, mb;
        logic       go;
        int         lat, xe, xm, xo, xl, seen;

        vt[0] = '{ea:8'h80, ma:8'h00, eb:8'h80, mb:8'h00, xe:8'h81, xm:8'h00, xo:1'b0, xl:3};
        vt[1] = '{ea:8'h82, ma:8'h80, eb:8'h80, mb:8'h00, xe:8'h82, xm:8'hC0, xo:1'b0, xl:5};
        vt[2] = '{ea:8'h80, ma:8'h00, eb:8'h82, mb:8'h80, xe:8'h82, xm:8'hC0, xo:1'b0, xl:5};
        vt[3] = '{ea:8'h90, ma:8'h55, eb:8'h80, mb:8'hFF, xe:8'h90, xm:8'h55, xo:1'b0, xl:12};
        vt[4] = '{ea:8'hFF, ma:8'h00, eb:8'hFF, mb:8'h00, xe:8'hFF, xm:8'h00, xo:1'b1, xl:3};
        vt[5] = '{ea:8'h00, ma:8'h00, eb:8'h85, mb:8'h3C, xe:8'h85, xm:8'h3C, xo:1'b0, xl:12};
        vt[6] = '{ea:8'h80, ma:8'hFF, eb:8'h80, mb:8'hFF, xe:8'h81, xm:8'hFF, xo:1'b0, xl:3};
        vt[7] = '{ea:8'h88, ma:8'h00, eb:8'h80, mb:8'h00, xe:8'h88, xm:8'h01, xo:1'b0, xl:11};

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        exp_a = '0; mant_a = '0; exp_b = '0; mant_b = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_exp_res", 32'(exp_res), 32'd0);
        chk("rst_mant_res", 32'(mant_res), 32'd0);
        chk("rst_ovf", 32'(ovf), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed table
        for (int i = 0; i < 8; i++) begin
            run_op(vt[i].ea, vt[i].ma, vt[i].eb, vt[i].mb, ge, gm, go, lat);
            chk($sformatf("vec%0d_exp", i), 32'(ge), 32'(vt[i].xe));
            chk($sformatf("vec%0d_mant", i), 32'(gm), 32'(vt[i].xm));
            chk($sformatf("vec%0d_ovf", i), 32'(go), 32'(vt[i].xo));
            chk($sformatf("vec%0d_lat", i), 32'(lat), 32'(vt[i].xl));
        end

        // Randomized operations against the reference model
        for (int i = 0; i < 40; i++) begin
            ea = 8'($urandom_range(0, 255)); ma = 8'($urandom);
            eb = 8'($urandom_range(0, 255)); mb = 8'($urandom);
            if (i % 3 == 0) eb = ea ^ 8'($urandom_range(0, 3));
            if (i % 7 == 0) begin ea = 8'h00; ma = 8'h00; end
            if (i % 11 == 5) begin ea = 8'hFF; eb = 8'hFE; end
            model(int'(ea), int'(ma), int'(eb), int'(mb), xe, xm, xo, xl);
            run_op(ea, ma, eb, mb, ge, gm, go, lat);
            chk($sformatf("rnd%0d_exp", i), 32'(ge), 32'(xe));
            chk($sformatf("rnd%0d_mant", i), 32'(gm), 32'(xm));
            chk($sformatf("rnd%0d_ovf", i), 32'(go), 32'(xo));
            chk($sformatf("rnd%0d_lat", i), 32'(lat), 32'(xl));
        end

        // Backpressure: hold result for 10 cycles while new operands are offered
        exp_a = 8'h82; mant_a = 8'h80; exp_b = 8'h80; mant_b = 8'h00;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (out_valid !== 1'b1 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("bp_lat", 32'(lat), 32'd5);
        exp_a = 8'hFF; mant_a = 8'hFF; exp_b = 8'hFF; mant_b = 8'hFF;
        in_valid = 1'b1;
        for (int c = 0; c < 10; c++) begin
            chk("bp_out_valid", 32'(out_valid), 32'd1);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            chk("bp_exp", 32'(exp_res), 32'h82);
            chk("bp_mant", 32'(mant_res), 32'hC0);
            chk("bp_ovf", 32'(ovf), 32'd0);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("bp_release_valid", 32'(out_valid), 32'd0);
        chk("bp_release_ready", 32'(in_ready), 32'd1);

        // Reset in the middle of a long alignment
        exp_a = 8'h90; mant_a = 8'h55; exp_b = 8'h80; mant_b = 8'hFF;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("mid_align_busy", 32'(in_ready), 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", 32'(out_valid), 32'd0);
        chk("arst_in_ready", 32'(in_ready), 32'd1);
        chk("arst_exp_res", 32'(exp_res), 32'd0);
        chk("arst_mant_res", 32'(mant_res), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        seen = 0;
        for (int c = 0; c < 15; c++) begin
            @(posedge clk); #1;
            if (out_valid === 1'b1) seen++;
        end
        chk("no_stale_result", 32'(seen), 32'd0);
        chk("idle_after_rst", 32'(in_ready), 32'd1);

        // Recovery after reset
        run_op(vt[1].ea, vt[1].ma, vt[1].eb, vt[1].mb, ge, gm, go, lat);
        chk("post_rst_exp", 32'(ge), 32'(vt[1].xe));
        chk("post_rst_mant", 32'(gm), 32'(vt[1].xm));
        chk("post_rst_lat", 32'(lat), 32'(vt[1].xl));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
